// File: rtl/agu_line_secq_unit.sv
// agu_line_secq_unit
// Store-AGU helper. It computes the address of the next 128-byte cache line
// within a 16 KB window, along with the wrap carry and the even/odd bank line
// indices. It also runs the pointer security/canonical range check.
// All results are registered once, which lines them up with the TLB-lookup stage.
//
// Optional feature macro: SECQ_CHECK_EN
//   defined   : range check active (non-canonical qualified pointers fault)
//   undefined : check forced to pass; o_secq_ok=1, o_fault=0, o_fault_cnt=0
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_en         operation valid this cycle
//   i_addr       64-bit effective address
//   i_cin_secq   security-qualified pointer (1 = check required)
//   i_ptrdiff    pointer-difference op, bypasses the range check
//   o_next_addr  {1'b0,addr[ADD_W-2:0]} + LINE_INC
//   o_line_cross carry out of the adder (next line wraps past 16 KB)
//   o_odd        addr[7]
//   o_even_idx   even-bank line index
//   o_odd_idx    odd-bank line index
//   o_secq_ok    range check pass
//   o_fault      valid & ~secq_ok
//   o_valid      registered i_en
//   o_fault_cnt  saturating fault count since reset
module agu_line_secq_unit #(
  parameter int unsigned ADD_W    = 15,
  parameter int unsigned LINE_INC = 128,
  parameter int unsigned VA_BITS  = 44
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [63:0]      i_addr,
  input  logic             i_cin_secq,
  input  logic             i_ptrdiff,
  output logic [ADD_W-1:0] o_next_addr,
  output logic             o_line_cross,
  output logic             o_odd,
  output logic [4:0]       o_even_idx,
  output logic [4:0]       o_odd_idx,
  output logic             o_secq_ok,
  output logic             o_fault,
  output logic             o_valid,
  output logic [7:0]       o_fault_cnt
);

  localparam int unsigned ExtW = 64 - VA_BITS;

  logic [ADD_W-1:0] w_sum;
  logic             w_ok;
  logic             w_odd;
  logic [4:0]       w_even_idx;
  logic [4:0]       w_odd_idx;

  // Only the low ADD_W-1 address bits feed the adder. The top bit of the sum is
  // the carry.
  assign w_sum = {1'b0, i_addr[ADD_W-2:0]} + ADD_W'(LINE_INC);

  // If the current line is odd, the next line (even) comes from the sum. The
  // odd bank keeps the current index. If the current line is even, the roles
  // swap.
  assign w_odd      = i_addr[7];
  assign w_even_idx = w_odd ? w_sum[12:8]  : i_addr[12:8];
  assign w_odd_idx  = w_odd ? i_addr[12:8] : w_sum[12:8];

`ifdef SECQ_CHECK_EN
  logic w_canon;
  assign w_canon = (i_addr[63:VA_BITS] == {ExtW{i_addr[VA_BITS-1]}});
  assign w_ok    = ~i_cin_secq | i_ptrdiff | w_canon;
`else
  assign w_ok = 1'b1;
`endif

  // Inputs that are left unused when the range check is compiled out.
  logic w_unused;
  assign w_unused = ^{i_addr, i_cin_secq, i_ptrdiff};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_next_addr  <= '0;
      o_line_cross <= 1'b0;
      o_odd        <= 1'b0;
      o_even_idx   <= '0;
      o_odd_idx    <= '0;
      o_secq_ok    <= 1'b1;
      o_fault      <= 1'b0;
      o_valid      <= 1'b0;
      o_fault_cnt  <= '0;
    end else begin
      // Data outputs track the inputs every cycle. i_en qualifies only valid
      // and fault.
      o_next_addr  <= w_sum;
      o_line_cross <= w_sum[ADD_W-1];
      o_odd        <= w_odd;
      o_even_idx   <= w_even_idx;
      o_odd_idx    <= w_odd_idx;
      o_secq_ok    <= w_ok;
      o_fault      <= i_en & ~w_ok;
      o_valid      <= i_en;
      // The counter follows the registered fault pulse, so it lags by one cycle.
      if (o_fault && (o_fault_cnt != 8'hFF)) begin
        o_fault_cnt <= o_fault_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_agu_line_secq_unit.sv
module tb_agu_line_secq_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [63:0] addr;
  logic        cin_secq;
  logic        ptrdiff;
  logic [14:0] next_addr;
  logic        line_cross;
  logic        odd;
  logic [4:0]  even_idx;
  logic [4:0]  odd_idx;
  logic        secq_ok;
  logic        fault;
  logic        valid;
  logic [7:0]  fault_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SECQ_CHECK_EN
  localparam bit ChkOn = 1'b1;
`else
  localparam bit ChkOn = 1'b0;
`endif

  agu_line_secq_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_addr       (addr),
    .i_cin_secq   (cin_secq),
    .i_ptrdiff    (ptrdiff),
    .o_next_addr  (next_addr),
    .o_line_cross (line_cross),
    .o_odd        (odd),
    .o_even_idx   (even_idx),
    .o_odd_idx    (odd_idx),
    .o_secq_ok    (secq_ok),
    .o_fault      (fault),
    .o_valid      (valid),
    .o_fault_cnt  (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; addr = '0; cin_secq = 1'b0; ptrdiff = 1'b0;
    step();
    step();
    check("rst_next_addr", 64'(next_addr), 64'h0);
    check("rst_line_cross", 64'(line_cross), 64'h0);
    check("rst_odd", 64'(odd), 64'h0);
    check("rst_even_idx", 64'(even_idx), 64'h0);
    check("rst_odd_idx", 64'(odd_idx), 64'h0);
    check("rst_secq_ok", 64'(secq_ok), 64'h1);
    check("rst_fault", 64'(fault), 64'h0);
    check("rst_valid", 64'(valid), 64'h0);
    check("rst_fault_cnt", 64'(fault_cnt), 64'h0);

    // Reset release together with en=1 is sampled on the first edge after release.
    rst = 1'b0; en = 1'b1; addr = 64'h0000_0000_0000_1F40;
    step();
    check("a1_next_addr", 64'(next_addr), 64'h1FC0);
    check("a1_line_cross", 64'(line_cross), 64'h0);
    check("a1_odd", 64'(odd), 64'h0);
    check("a1_even_idx", 64'(even_idx), 64'h1F);
    check("a1_odd_idx", 64'(odd_idx), 64'h1F);
    check("a1_valid", 64'(valid), 64'h1);
    check("a1_secq_ok", 64'(secq_ok), 64'h1);

    addr = 64'h0000_0000_0000_3FC0;
    step();
    check("a2_next_addr", 64'(next_addr), 64'h4040);
    check("a2_line_cross", 64'(line_cross), 64'h1);
    check("a2_odd", 64'(odd), 64'h1);
    check("a2_even_idx", 64'(even_idx), 64'h00);
    check("a2_odd_idx", 64'(odd_idx), 64'h1F);

    // Upper bits [43:14] do not reach the adder.
    addr = 64'h0000_0ABC_DEF0_1F40;
    step();
    check("a3_next_addr", 64'(next_addr), 64'h1FC0);
    check("a3_line_cross", 64'(line_cross), 64'h0);

    // The data path registers even when en=0.
    en = 1'b0; addr = 64'h0000_0000_0000_0180;
    step();
    check("idle_valid", 64'(valid), 64'h0);
    check("idle_next_addr", 64'(next_addr), 64'h0200);
    check("idle_odd", 64'(odd), 64'h1);
    check("idle_even_idx", 64'(even_idx), 64'h02);
    check("idle_odd_idx", 64'(odd_idx), 64'h01);

    // Non-canonical pointer that is qualified.
    en = 1'b1; cin_secq = 1'b1; ptrdiff = 1'b0; addr = 64'h0001_0000_0000_0000;
    step();
    check("nc_secq_ok", 64'(secq_ok), ChkOn ? 64'h0 : 64'h1);
    check("nc_fault", 64'(fault), ChkOn ? 64'h1 : 64'h0);
    check("nc_cnt_lag", 64'(fault_cnt), 64'h0);
    check("nc_next_addr", 64'(next_addr), 64'h0080);

    en = 1'b0; cin_secq = 1'b0;
    step();
    check("nc_cnt_after", 64'(fault_cnt), ChkOn ? 64'h1 : 64'h0);
    check("nc_fault_idle", 64'(fault), 64'h0);

    en = 1'b1; cin_secq = 1'b1; ptrdiff = 1'b1;
    step();
    check("pd_secq_ok", 64'(secq_ok), 64'h1);
    check("pd_fault", 64'(fault), 64'h0);

    cin_secq = 1'b0; ptrdiff = 1'b0;
    step();
    check("nq_secq_ok", 64'(secq_ok), 64'h1);
    check("nq_fault", 64'(fault), 64'h0);

    // Canonical negative address (bits 63:43 all set).
    cin_secq = 1'b1; addr = 64'hFFFF_F800_0000_0000;
    step();
    check("cn_secq_ok", 64'(secq_ok), 64'h1);
    check("cn_fault", 64'(fault), 64'h0);

    // Canonical boundary: bit 43 clear while bit 44 is set.
    addr = 64'h0000_1000_0000_0000;
    step();
    check("b44_secq_ok", 64'(secq_ok), ChkOn ? 64'h0 : 64'h1);
    en = 1'b0; cin_secq = 1'b0; addr = '0;
    step();
    check("b44_cnt", 64'(fault_cnt), ChkOn ? 64'h2 : 64'h0);

    // Run faulting ops back to back. The count starts at 2 if checking is on.
    // After n faulting edges, the count is 2 + (n - 1).
    en = 1'b1; cin_secq = 1'b1; ptrdiff = 1'b0; addr = 64'h0001_0000_0000_0000;
    for (int i = 0; i < 10; i++) step();
    check("sat_cnt_10", 64'(fault_cnt), ChkOn ? 64'd11 : 64'd0);
    for (int i = 0; i < 243; i++) step();
    check("sat_cnt_253", 64'(fault_cnt), ChkOn ? 64'd254 : 64'd0);
    step();
    check("sat_cnt_254", 64'(fault_cnt), ChkOn ? 64'd255 : 64'd0);
    for (int i = 0; i < 46; i++) step();
    check("sat_cnt_300", 64'(fault_cnt), ChkOn ? 64'd255 : 64'd0);
    check("sat_fault", 64'(fault), ChkOn ? 64'h1 : 64'h0);

    // Reset takes priority over en and drops the in-flight result.
    rst = 1'b1;
    step();
    check("rst2_fault_cnt", 64'(fault_cnt), 64'h0);
    check("rst2_secq_ok", 64'(secq_ok), 64'h1);
    check("rst2_fault", 64'(fault), 64'h0);
    check("rst2_valid", 64'(valid), 64'h0);
    check("rst2_next_addr", 64'(next_addr), 64'h0);

    rst = 1'b0;
    step();
    check("post_valid", 64'(valid), 64'h1);
    check("post_fault", 64'(fault), ChkOn ? 64'h1 : 64'h0);
    check("post_cnt", 64'(fault_cnt), 64'h0);
    en = 1'b0;
    step();
    check("post_cnt2", 64'(fault_cnt), ChkOn ? 64'h1 : 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
